// File: rtl/mem_rr_arbiter.sv
// Round-robin shared-memory-port arbiter with owner hold, done/drop release and hold-budget preemption.
// Optional preemption statistics counter enabled by defining MEM_ARB_STATS_EN.
module mem_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = 2
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  done,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    output logic                preempt
`ifdef MEM_ARB_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [15:0]         preempt_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [7:0]      HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [7:0]          hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                preempt_q, preempt_d;

    logic [ID_W-1:0]     win;
    logic                win_found;
    logic [ID_W-1:0]     scan_idx;

    // Upward scan from ptr; wrap is an explicit compare so non-power-of-two NUM_REQ works.
    always_comb begin
        win       = ptr_q;
        win_found = 1'b0;
        scan_idx  = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req[scan_idx]) begin
                win       = scan_idx;
                win_found = 1'b1;
            end
            scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + ID_W'(1);
        end
    end

    logic owner_done;
    logic owner_req;
    logic hold_limit;

    assign owner_done = done[grant_id_q];
    assign owner_req  = req[grant_id_q];
    assign hold_limit = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        preempt_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                grant_d = '0;
                if (win_found) begin
                    state_d       = ST_OWN;
                    grant_d[win]  = 1'b1;
                    grant_id_d    = win;
                    hold_cnt_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (owner_done || !owner_req || hold_limit) begin
                    state_d   = ST_GAP;
                    grant_d   = '0;
                    ptr_d     = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
                    // Only a pure timeout counts as preemption; a coincident done is a normal release.
                    preempt_d = hold_limit && !owner_done && owner_req;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q == ST_OWN);
    assign preempt  = preempt_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] preempt_cnt_q;

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            preempt_cnt_q <= '0;
        end else if (stats_clr) begin
            preempt_cnt_q <= '0;
        end else if (preempt_q && (preempt_cnt_q != 16'hFFFF)) begin
            preempt_cnt_q <= preempt_cnt_q + 16'd1;
        end
    end

    assign preempt_cnt = preempt_cnt_q;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed, table-driven bench for mem_rr_arbiter (NUM_REQ=4, MAX_HOLD=16).
// Stats checks run only when MEM_ARB_STATS_EN is defined.
module tb_mem_rr_arbiter;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst = 1'b0;
    logic [3:0] req     = '0;
    logic [3:0] done    = '0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       preempt;
`ifdef MEM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] preempt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mem_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(16), .ID_W(2)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .preempt  (preempt)
`ifdef MEM_ARB_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .preempt_cnt (preempt_cnt)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       p;
    } vec_t;

    vec_t vecs[23];

    initial begin
        // Inputs applied before an edge; expectations are outputs after that edge.
        vecs[0]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[3]  = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[6]  = '{4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[7]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[8]  = '{4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[9]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[10] = '{4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[11] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[14] = '{4'b1111, 4'b1101, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[15] = '{4'b1101, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[17] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[18] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[19] = '{4'b0010, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[20] = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[21] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[22] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};

        // Reset state
        cpu_rst = 1'b0;
        tick();
        tick();
        chk("rst_grant",   32'(grant),    32'h0);
        chk("rst_id",      32'(grant_id), 32'h0);
        chk("rst_busy",    32'(busy),     32'h0);
        chk("rst_preempt", 32'(preempt),  32'h0);
`ifdef MEM_ARB_STATS_EN
        chk("rst_cnt", 32'(preempt_cnt), 32'h0);
`endif
        cpu_rst = 1'b1;
        tick();
        chk("idle_grant", 32'(grant), 32'h0);

        for (int i = 0; i < 23; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            tick();
            chk($sformatf("v%0d_grant", i),   32'(grant),    32'(vecs[i].g));
            chk($sformatf("v%0d_id", i),      32'(grant_id), 32'(vecs[i].id));
            chk($sformatf("v%0d_busy", i),    32'(busy),     32'(vecs[i].b));
            chk($sformatf("v%0d_preempt", i), 32'(preempt),  32'(vecs[i].p));
        end

        // Hold-limit preemption with a single persistent requester.
        req  = 4'b0001;
        done = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("hold_grant_%0d", k), 32'(grant), 32'h1);
            chk($sformatf("hold_nopre_%0d", k), 32'(preempt), 32'h0);
        end
        tick();
        chk("timeout_grant",   32'(grant),   32'h0);
        chk("timeout_preempt", 32'(preempt), 32'h1);
        chk("timeout_busy",    32'(busy),    32'h0);
        tick();
        chk("regrant_grant",   32'(grant),   32'h1);
        chk("regrant_id",      32'(grant_id), 32'h0);
        chk("regrant_preempt", 32'(preempt), 32'h0);

        // done coincident with the hold limit is a normal release.
        for (int k = 0; k < 15; k++) begin
            tick();
        end
        chk("pre_limit_grant", 32'(grant), 32'h1);
        done = 4'b0001;
        tick();
        chk("done_limit_grant",   32'(grant),   32'h0);
        chk("done_limit_preempt", 32'(preempt), 32'h0);
        done = 4'b0000;
        req  = 4'b0000;
        tick();
        chk("after_gap_idle", 32'(grant), 32'h0);

`ifdef MEM_ARB_STATS_EN
        chk("cnt_one", 32'(preempt_cnt), 32'h1);
        req = 4'b0001;
        for (int k = 0; k < 34; k++) begin
            tick();
        end
        chk("second_pre_pulse", 32'(preempt), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        tick();
        chk("cnt_three", 32'(preempt_cnt), 32'h3);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("cnt_cleared", 32'(preempt_cnt), 32'h0);
`endif

        // Asynchronous reset while an owner holds the port.
        req = 4'b0100;
        tick();
        chk("pre_rst_grant", 32'(grant), 32'h4);
        #2;
        cpu_rst = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant),    32'h0);
        chk("async_rst_busy",  32'(busy),     32'h0);
        chk("async_rst_id",    32'(grant_id), 32'h0);
        #1;
        cpu_rst = 1'b1;
        req = 4'b1000;
        tick();
        chk("post_rst_grant", 32'(grant),    32'h8);
        chk("post_rst_id",    32'(grant_id), 32'h3);
        req = 4'b0000;
        tick();
        tick();
        // ptr restarted at 0 after reset: with 1010 pending, owner 3 released -> ptr 0 -> winner 1.
        req = 4'b1010;
        tick();
        chk("ptr_after_rst_id", 32'(grant_id), 32'h1);
        req = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter with hold and preemption for the shared memory port in the CPU domain.
- Up to NUM_REQ masters request the port. One owner is granted at a time, and the owner keeps the port until it signals done, drops its request, or exceeds a hold budget.
- Replaces the free-running two-way toggle arbitration with a fair, handshaked, bounded-latency controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant (2..255).
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).

Ports:
- cpu_clk  input  1  clock; all logic is on the rising edge.
- cpu_rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-master request level; held high while the master wants the port.
- done  input  NUM_REQ  per-master release pulse; only the current owner's bit is honoured.
- grant  output  NUM_REQ  registered one-hot grant; all zero when no owner.
- grant_id  output  ID_W  index of the current owner; holds the last owner when idle.
- busy  output  1  high while any grant bit is high.
- preempt  output  1  one-cycle pulse when an owner is forcibly released on hold timeout.

Behaviour:
- Reset (cpu_rst low, takes effect immediately):
  - grant=0, grant_id=0, busy=0, preempt=0.
  - ptr=0, hold_cnt=0, state=IDLE.
- State machine: IDLE, OWN, GAP.
- IDLE:
  - If req is nonzero, select the first set bit scanning upward from ptr, wrapping modulo NUM_REQ.
  - Next cycle: state=OWN, grant=onehot(winner), grant_id=winner, hold_cnt=0.
  - Latency is one cycle from req sampled high to grant high.
- OWN:
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - The owner is released when any of these is true:
    - done[owner]=1
    - req[owner]=0
    - hold_cnt==MAX_HOLD-1
  - On release: next cycle grant=0, state=GAP, ptr=(owner+1) mod NUM_REQ.
  - If release happens only because of the hold limit (done=0 and req=1), preempt pulses high in that same next cycle.
  - done or req bits of non-owners are ignored.
- GAP:
  - grant is zero for exactly one cycle as a bus turnaround.
  - The GAP cycle evaluates arbitration exactly as IDLE does, using the updated ptr.
  - If a request is present, the next cycle is OWN; otherwise the next cycle is IDLE.
  - Consecutive owners are therefore separated by exactly one zero-grant cycle.
- Grant duration: a granted owner holds grant for at most MAX_HOLD cycles.
- Fairness: any requester that holds req continuously is granted within (NUM_REQ-1)*(MAX_HOLD+1)+1 cycles.
- Simultaneous events:
  - done and hold-limit in the same cycle count as a normal release; preempt stays 0.
  - A single requester that is preempted and still requesting is re-granted after the GAP cycle.
- Arithmetic:
  - ptr and winner are ID_W bits; wrap uses explicit compare against NUM_REQ-1, not power-of-two truncation.
  - hold_cnt is 8 bits.
- Mid-operation reset: grant drops asynchronously, and arbitration restarts from ptr=0.
- busy is derived from registered state (busy = state==OWN), so it is glitch-free.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- With the macro defined:
  - Adds output preempt_cnt[15:0], a saturating count of preempt pulses.
  - Adds input stats_clr; stats_clr=1 zeroes the count on the next edge, and clear wins over a simultaneous increment.
  - The count resets to 0.
- Without the macro: neither port exists and there is no counter logic; arbitration behaviour is identical.

Test Plan:
- Reset, then req=4'b0001 at cycle 0 -> grant=0001, grant_id=0 at cycle 1; done[0] at cycle 3 -> grant=0000 at cycle 4; busy follows grant.
- req=4'b1111 held, done pulsed on the 2nd cycle of each ownership -> grants rotate 0001, 0010, 0100, 1000, 0001 with exactly one zero-grant cycle between owners.
- req=4'b0001 held, no done, MAX_HOLD=16 -> grant high for 16 cycles; preempt=1 in the following GAP cycle; re-grant to 0 one cycle later.
- req=0011, owner 0 drops req while done[1] pulses -> owner 0 released (done[1] ignored); next owner is 1.
- cpu_rst asserted low mid-OWN -> grant=0 immediately without a clock edge; after release, req=1000 -> grant=1000 one cycle later.
- MEM_ARB_STATS_EN defined, three forced preemptions -> preempt_cnt=3; stats_clr pulse -> preempt_cnt=0 on the next edge.
